// File: rtl/rv32c_fetch_requester_pkg.sv
// rv32c_fetch_pkg: shared types and constants for the RV32C fetch requester
package rv32c_fetch_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} fetch_state_t;
    typedef struct packed {
        logic [31:0] word;
        logic [31:0] addr;
    } fetch_entry_t;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/rv32c_fetch_requester_if.sv
// rv32c_fetch_requester_if: imem read port and fetch-buffer word handshake
interface rv32c_fetch_requester_if;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        imem_busy;
    logic [31:0] imem_rdata;
    logic        word_valid;
    logic [31:0] word_out;
    logic [31:0] word_addr;
    logic        word_ack;
    modport master (
        output imem_ren, imem_addr, word_valid, word_out, word_addr,
        input  imem_busy, imem_rdata, word_ack
    );
    modport slave (
        input  imem_ren, imem_addr, word_valid, word_out, word_addr,
        output imem_busy, imem_rdata, word_ack
    );
endinterface

// File: rtl/rv32c_fetch_requester_fifo.sv
// fetch_word_fifo: word/address queue; flush overrides push and pop
module fetch_word_fifo
    import rv32c_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;
    always_comb begin
        full    = cnt == (AW+1)'(DEPTH);
        empty   = cnt == '0;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = mem[rp];
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
    always_ff @(posedge clk) begin
        if (!nrst || flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/rv32c_fetch_requester.sv
// rv32c_fetch_requester: single-outstanding word fetcher for the RV32C fetch buffer
// optional perf counters behind RV32C_FETCH_PERF_EN
module rv32c_fetch_requester
    import rv32c_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h80000000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        dmem_busy,
`ifdef RV32C_FETCH_PERF_EN
    output logic [31:0] perf_fetches,
    output logic [31:0] perf_discards,
`endif
    rv32c_fetch_requester_if.master bus
);
    fetch_state_t state, state_d;
    logic [31:0]  fetch_pc, pc_d, addr_d;
    logic         push, pop, start, full, empty;
    fetch_entry_t entry, head;

    fetch_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_en),
        .din   (entry),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state         <= IDLE;
            fetch_pc      <= RESET_PC;
            bus.imem_ren  <= 1'b0;
            bus.imem_addr <= RESET_PC & ~32'd3;
        end else begin
            state         <= state_d;
            fetch_pc      <= pc_d;
            bus.imem_ren  <= state_d != IDLE;
            bus.imem_addr <= addr_d;
        end
    end

    // a full queue may still start a read when the head leaves this cycle
    always_comb begin
        start   = state == IDLE && (!full || pop) && !dmem_busy && !redirect_en;
        state_d = state == IDLE ? (start ? FETCH : IDLE)
                : state == FETCH && redirect_en ? (bus.imem_busy ? DISCARD : IDLE)
                : bus.imem_busy ? state : IDLE;
    end

    always_comb begin
        pop            = bus.word_ack && !empty && !redirect_en;
        push           = state == FETCH && !bus.imem_busy && !redirect_en;
        entry          = '{word: bus.imem_rdata, addr: fetch_pc};
        pc_d           = redirect_en ? {redirect_pc[31:1], 1'b0}
                       : push ? {fetch_pc[31:2], 2'b00} + 32'(WORD_BYTES) : fetch_pc;
        addr_d         = start ? {fetch_pc[31:2], 2'b00} : bus.imem_addr;
        bus.word_valid = !empty;
        bus.word_out   = empty ? '0 : head.word;
        bus.word_addr  = empty ? '0 : head.addr;
    end

`ifdef RV32C_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!nrst) begin
            perf_fetches  <= '0;
            perf_discards <= '0;
        end else begin
            if (push && ~&perf_fetches) perf_fetches <= perf_fetches + 1'b1;
            if (state == FETCH && redirect_en && ~&perf_discards) perf_discards <= perf_discards + 1'b1;
        end
    end
`endif
endmodule

// File: doc/rv32c_fetch_requester.md
Name: rv32c_fetch_requester

Overview:
Producer side of the RV32C fetch-buffer word interface. Issues word-aligned reads to instruction memory and queues the returned 32-bit words with their addresses. Presents the words to the fetch buffer/decompressor with a valid/ack handshake. Handles PC redirects, including a redirect that arrives while a read is in flight, and yields the memory port while the data side is busy.

Parameters:
RESET_PC, 32'h80000000, address of the first fetch after reset
FIFO_DEPTH, 2, number of entries in the output word queue; must be a power of 2 and at least 2

Ports:
clk  input  1  clock
nrst  input  1  synchronous active-low reset
redirect_en  input  1  flush and restart fetch at redirect_pc; single-cycle pulse
redirect_pc  input  32  new PC, halfword-aligned (bit 0 ignored)
dmem_busy  input  1  data-side access pending; no new imem read may start
imem_busy  input  1  imem read in progress; rdata is valid in the cycle busy is low
imem_rdata  input  32  read data
imem_ren  output  1  read request
imem_addr  output  32  read address, always word-aligned
word_valid  output  1  head of queue is valid
word_out  output  32  head word
word_addr  output  32  head PC; bit 1 set only for a first word entered mid-word
word_ack  input  1  consumer takes head; ignored when word_valid=0

Behaviour:
- Reset (nrst=0 at a clk edge): state=IDLE, fetch_pc=RESET_PC, queue empty, word_valid=0, imem_ren=0, imem_addr=RESET_PC & ~3, word_out=0, word_addr=0. If nrst is asserted mid-read, the in-flight read is abandoned without waiting for imem_busy.
- FSM states: IDLE, FETCH, DISCARD.
- IDLE -> FETCH when the queue has a free slot (counting no reservation) and dmem_busy=0 and redirect_en=0. imem_ren=1 and imem_addr={fetch_pc[31:2],2'b00} are registered on entry.
- FETCH: hold imem_ren and imem_addr stable until imem_busy=0. In that cycle, push {imem_rdata, fetch_pc}, set fetch_pc={fetch_pc[31:2]+1,2'b00}, and drop imem_ren. Next state is IDLE. Back-to-back reads are not required; there is at most 1 outstanding read.
- Redirect in IDLE: flush the queue (word_valid=0 next cycle) and set fetch_pc=redirect_pc & ~1.
- Redirect in FETCH with imem_busy=1: flush the queue, load fetch_pc, go to DISCARD. ren stays asserted until busy=0, and that data is dropped. DISCARD -> IDLE when imem_busy=0.
- Redirect in FETCH in the same cycle imem_busy=0: redirect wins. The word is not pushed and the next state is IDLE.
- Redirect in DISCARD: update fetch_pc only and stay in DISCARD.
- Redirect and word_ack in the same cycle: the flush wins and the ack is a no-op.
- Queue: full means FIFO_DEPTH entries. A push and an ack in the same cycle are both legal when full. A read is never started while full unless an ack is present in the same cycle. Empty means word_valid=0. Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Latency: after reset or redirect with an immediate grant, imem_ren rises 1 cycle later. word_valid rises in the cycle after imem_busy falls.
- word_addr for a redirect to PC with bit1=1 keeps bit1=1 on the first word only; later words are aligned.

Optional Feature:
RV32C_FETCH_PERF_EN: adds outputs perf_fetches[31:0] (completed, pushed reads) and perf_discards[31:0] (reads dropped by a redirect). Both are reset to 0 and saturate at 32'hFFFFFFFF. Without the macro these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package rv32c_fetch_pkg: fetch_state_t enum (IDLE, FETCH, DISCARD); fetch_entry_t struct {word[31:0], addr[31:0]}; WORD_BYTES=4.
- Sub-module fetch_word_fifo (parameter DEPTH, fetch_entry_t storage): push, pop, flush, full, empty; flush has priority over push and pop.

Test Plan:
- Reset, imem_busy low after 2 cycles with rdata=32'h00010001 -> imem_addr=32'h80000000; word_valid=1, word_addr=32'h80000000; next read at 32'h80000004.
- word_ack held 0, imem always ready -> exactly 2 words queued, imem_ren stays 0; a single ack triggers one new read.
- redirect_en with redirect_pc=32'h80000106 while busy=1 -> DISCARD; stale rdata is not enqueued; next read at 32'h80000104 with word_addr=32'h80000106, then 32'h80000108.
- dmem_busy=1 for 5 cycles while IDLE with a free slot -> imem_ren stays 0; the read issues 1 cycle after dmem_busy falls.
- Redirect and word_ack in the same cycle, plus redirect coinciding with imem_busy falling -> queue empty, no push, fetch restarts at the new PC.
- With RV32C_FETCH_PERF_EN, 3 completed reads and 1 discard -> perf_fetches=3, perf_discards=1; both reset to 0.
